cmv300_sensor_emu: RTL and testbench

CMV300_SENSOR_EMU -- requirements
Module: cmv300_sensor_emu

---
 rtl/cmv300_pkg.sv | 26 ++
 rtl/cmv300_sensor_emu.sv | 146 ++++++++++++++
 tb/tb_cmv300_sensor_emu.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmv300_pkg.sv
// Shared types and constants for the CMV300 sensor emulator.
// The LFSR constants are only used when CMV300_EMU_LFSR_EN is defined.
package cmv300_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_LINE   = 2'd2,
        ST_HBLANK = 2'd3
    } state_t;

    localparam int PIX_W  = 10;
    localparam int LINE_W = 10;
    localparam int DLY_W  = 8;
    localparam int BLK_W  = 8;
    localparam int CNT_W  = 16;

    // x^8+x^6+x^5+x^4+1 in Fibonacci form: feedback from bits 7,5,4,3
    localparam logic [7:0] LFSR_SEED = 8'hFF;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/cmv300_sensor_emu.sv
// CMV300 image sensor emulator: frame/line timing with a test pattern on d.
// Define CMV300_EMU_LFSR_EN to replace the counting pattern with an 8-bit LFSR.
module cmv300_sensor_emu
    import cmv300_pkg::*;
#(
    parameter int LINE_PIXELS = 648,
    parameter int FRAME_LINES = 488,
    parameter int H_BLANK     = 16,
    parameter int FRAME_DELAY = 8
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             frame_req,
    output logic             line_valid,
    output logic             data_valid,
    output logic [7:0]       d,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(LINE_PIXELS - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(FRAME_LINES - 1);
    localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(FRAME_DELAY - 1);
    localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(H_BLANK - 1);

    state_t             state_reg;
    logic [PIX_W-1:0]   pix_cnt_reg;
    logic [LINE_W-1:0]  line_cnt_reg;
    logic [DLY_W-1:0]   dly_cnt_reg;
    logic [BLK_W-1:0]   blk_cnt_reg;
    logic               req_prev_reg;
    logic               pend_reg;
    logic               fin_reg;
    logic               line_valid_reg;
    logic               busy_reg;
    logic               frame_done_reg;
    logic [7:0]         d_reg;
    logic [CNT_W-1:0]   frame_cnt_reg;
    logic               req_edge;
    logic [7:0]         pattern;

    assign req_edge = frame_req & ~req_prev_reg;

`ifdef CMV300_EMU_LFSR_EN
    logic [7:0] lfsr_reg;

    // Held at the seed outside a frame, so every frame restarts the sequence.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            lfsr_reg <= LFSR_SEED;
        end else if (state_reg == ST_IDLE) begin
            lfsr_reg <= LFSR_SEED;
        end else if (state_reg == ST_LINE) begin
            lfsr_reg <= lfsr_step(lfsr_reg);
        end
    end

    assign pattern = lfsr_reg;
`else
    assign pattern = pix_cnt_reg[7:0] + line_cnt_reg[7:0] + frame_cnt_reg[7:0];
`endif

    // Outputs are registered from the current state, so they trail the FSM by one cycle.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_reg      <= ST_IDLE;
            pix_cnt_reg    <= '0;
            line_cnt_reg   <= '0;
            dly_cnt_reg    <= '0;
            blk_cnt_reg    <= '0;
            req_prev_reg   <= 1'b0;
            pend_reg       <= 1'b0;
            fin_reg        <= 1'b0;
            line_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            d_reg          <= 8'h00;
            frame_cnt_reg  <= '0;
        end else begin
            req_prev_reg   <= frame_req;
            line_valid_reg <= (state_reg == ST_LINE);
            busy_reg       <= (state_reg != ST_IDLE);
            frame_done_reg <= fin_reg;
            fin_reg        <= 1'b0;
            d_reg          <= 8'h00;
            if (fin_reg) begin
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end
            // An edge during a frame (or its done cycle) is remembered once.
            if (req_edge && (state_reg != ST_IDLE || fin_reg)) begin
                pend_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (!fin_reg && (req_edge || pend_reg)) begin
                        state_reg   <= ST_DELAY;
                        dly_cnt_reg <= '0;
                        pend_reg    <= 1'b0;
                    end
                end
                ST_DELAY: begin
                    if (dly_cnt_reg == DLY_LAST) begin
                        state_reg    <= ST_LINE;
                        pix_cnt_reg  <= '0;
                        line_cnt_reg <= '0;
                    end else begin
                        dly_cnt_reg <= dly_cnt_reg + 1'b1;
                    end
                end
                ST_LINE: begin
                    d_reg       <= pattern;
                    pix_cnt_reg <= pix_cnt_reg + 1'b1;
                    if (pix_cnt_reg == PIX_LAST) begin
                        if (line_cnt_reg == LINE_LAST) begin
                            state_reg <= ST_IDLE;
                            fin_reg   <= 1'b1;
                        end else begin
                            state_reg   <= ST_HBLANK;
                            blk_cnt_reg <= '0;
                        end
                    end
                end
                ST_HBLANK: begin
                    if (blk_cnt_reg == BLK_LAST) begin
                        state_reg    <= ST_LINE;
                        pix_cnt_reg  <= '0;
                        line_cnt_reg <= line_cnt_reg + 1'b1;
                    end else begin
                        blk_cnt_reg <= blk_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign line_valid = line_valid_reg;
    assign data_valid = line_valid_reg;
    assign d          = d_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;
    assign frame_cnt  = frame_cnt_reg;

endmodule

// File: tb/tb_cmv300_sensor_emu.sv
// Self-checking bench for cmv300_sensor_emu with a small frame geometry.
// Expected outputs come from a frame-schedule model (start edge + arithmetic offsets).
module tb_cmv300_sensor_emu;

    localparam int P  = 4;
    localparam int L  = 3;
    localparam int H  = 2;
    localparam int FD = 3;
    localparam int T  = FD + L * P + (L - 1) * H;

    logic        clk;
    logic        res_n;
    logic        frame_req;
    logic        line_valid;
    logic        data_valid;
    logic [7:0]  d;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;

    cmv300_sensor_emu #(
        .LINE_PIXELS(P),
        .FRAME_LINES(L),
        .H_BLANK    (H),
        .FRAME_DELAY(FD)
    ) dut (
        .clk       (clk),
        .res_n     (res_n),
        .frame_req (frame_req),
        .line_valid(line_valid),
        .data_valid(data_valid),
        .d         (d),
        .busy      (busy),
        .frame_done(frame_done),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks_cnt = 0;
    int errors_cnt = 0;

    // Reference model: start edge of the current frame, pending flag, completed frames.
    int   cyc       = 0;
    int   act_start = -1;
    bit   m_pend    = 0;
    bit   m_prev    = 0;
    int   frames    = 0;

    // Per-scenario observations.
    int   busy_cnt;
    int   done_cnt;
    int   first_lv;
    bit   prev_busy;
    int   dq[$];
    int   s1_q[$];
    int   done_q[$];
    int   rise_q[$];
    int   pulse_cyc;
    int   exp_seq[12] = '{0, 1, 2, 3, 1, 2, 3, 4, 2, 3, 4, 5};

    task automatic check_val(input string tag, input int obs, input int exp);
        checks_cnt++;
        if (obs != exp) begin
            errors_cnt++;
            $display("FAIL %s observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

`ifdef CMV300_EMU_LFSR_EN
    function automatic int lfsr_nth(input int k);
        logic [7:0] v;
        v = 8'hFF;
        for (int i = 0; i < k; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        return int'(v);
    endfunction
`endif

    function automatic int expected_pixel(input int ln, input int px);
`ifdef CMV300_EMU_LFSR_EN
        return lfsr_nth(ln * P + px);
`else
        return (px + ln + frames) % 256;
`endif
    endfunction

    task automatic model_reset();
        act_start = -1;
        m_pend    = 0;
        m_prev    = 0;
        frames    = 0;
    endtask

    task automatic model_edge();
        bit edge_now;
        cyc++;
        if (!res_n) begin
            model_reset();
            return;
        end
        edge_now = frame_req && !m_prev;
        m_prev   = frame_req;
        if (act_start >= 0 && cyc == act_start + T + 1) frames = (frames + 1) % 65536;
        if (act_start >= 0 && cyc == act_start + T + 2 && m_pend) begin
            act_start = cyc;
            m_pend    = 0;
        end else if (edge_now) begin
            if (act_start >= 0 && cyc <= act_start + T + 1) m_pend = 1;
            else act_start = cyc;
        end
    endtask

    task automatic compare_outputs();
        int t, u, ln, px, ev_d;
        bit ev_busy, ev_lv, ev_done;
        ev_busy = 0; ev_lv = 0; ev_done = 0; ev_d = 0;
        if (res_n && act_start >= 0) begin
            t       = cyc - act_start;
            ev_busy = (t >= 1 && t <= T);
            ev_done = (t == T + 1);
            u       = t - (FD + 1);
            if (u >= 0) begin
                ln = u / (P + H);
                px = u % (P + H);
                if (ln < L && px < P) begin
                    ev_lv = 1;
                    ev_d  = expected_pixel(ln, px);
                end
            end
        end
        check_val("busy",       int'(busy),       int'(ev_busy));
        check_val("line_valid", int'(line_valid), int'(ev_lv));
        check_val("data_valid", int'(data_valid), int'(ev_lv));
        check_val("d",          int'(d),          ev_d);
        check_val("frame_done", int'(frame_done), int'(ev_done));
        check_val("frame_cnt",  int'(frame_cnt),  frames);
        busy_cnt += int'(busy);
        done_cnt += int'(frame_done);
        if (frame_done) done_q.push_back(cyc);
        if (busy && !prev_busy) rise_q.push_back(cyc);
        prev_busy = busy;
        if (line_valid && first_lv < 0) first_lv = cyc;
        if (data_valid) dq.push_back(int'(d));
    endtask

    task automatic scen_begin();
        busy_cnt = 0;
        done_cnt = 0;
        first_lv = -1;
        dq.delete();
        done_q.delete();
        rise_q.delete();
    endtask

    // Called at a negedge; drives frame_req, advances one clock, checks at the next negedge.
    task automatic cycle_step(input logic req_val);
        frame_req = req_val;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle_step(1'b0);
    endtask

    task automatic pulse();
        cycle_step(1'b1);
        pulse_cyc = cyc;
        frame_req = 1'b0;
    endtask

    // Asserted between edges, so the outputs must clear without a clock.
    task automatic apply_reset(input int hold);
        #2 res_n = 1'b0;
        #1;
        model_reset();
        compare_outputs();
        idle(hold);
        res_n = 1'b1;
    endtask

    initial begin
        res_n     = 1'b0;
        frame_req = 1'b0;
        prev_busy = 0;
        scen_begin();
        @(negedge clk);
        model_reset();
        idle(3);
        res_n = 1'b1;
        idle(2);

        // Single frame
        scen_begin();
        pulse();
        idle(25);
        check_val("s1_first_lv_delay", first_lv - pulse_cyc, FD + 1);
        check_val("s1_busy_cycles", busy_cnt, T);
        check_val("s1_done_pulses", done_cnt, 1);
        check_val("s1_pixels", dq.size(), L * P);
        check_val("s1_frame_cnt", int'(frame_cnt), 1);
`ifdef CMV300_EMU_LFSR_EN
        check_val("s1_lfsr_px0", dq[0], 8'hFF);
        check_val("s1_lfsr_px1", dq[1], 8'hFE);
        s1_q = dq;
`else
        for (int i = 0; i < L * P; i++) check_val("s1_seq", dq[i], exp_seq[i]);
`endif

        // Second frame after the first has completed
        scen_begin();
        pulse();
        idle(25);
`ifdef CMV300_EMU_LFSR_EN
        for (int i = 0; i < L * P; i++) check_val("s2_lfsr_repeat", dq[i], s1_q[i]);
`else
        for (int i = 0; i < P; i++) check_val("s2_line0", dq[i], i + 1);
`endif
        check_val("s2_frame_cnt", int'(frame_cnt), 2);

        // Two requests during a busy frame: one back-to-back frame
        apply_reset(2);
        idle(2);
        scen_begin();
        pulse();
        idle(5);
        pulse();
        idle(2);
        pulse();
        idle(50);
        check_val("s3_done_pulses", done_cnt, 2);
        check_val("s3_busy_rises", rise_q.size(), 2);
        check_val("s3_back_to_back", rise_q[1] - done_q[0], 2);
        check_val("s3_frame_cnt", int'(frame_cnt), 2);

        // Reset during line 1, then a fresh complete frame
        scen_begin();
        pulse();
        idle(FD + 1 + P + H + 1);
        apply_reset(2);
        scen_begin();
        idle(20);
        check_val("s4_quiet_busy", busy_cnt, 0);
        check_val("s4_quiet_pixels", dq.size(), 0);
        scen_begin();
        pulse();
        idle(25);
        check_val("s4_pixels", dq.size(), L * P);
        check_val("s4_done_pulses", done_cnt, 1);
        check_val("s4_frame_cnt", int'(frame_cnt), 1);

        // Request held high: edge-only acceptance
        scen_begin();
        for (int i = 0; i < 100; i++) cycle_step(1'b1);
        idle(30);
        check_val("s5_done_pulses", done_cnt, 1);
        check_val("s5_frame_cnt", int'(frame_cnt), 2);

        // Random request toggling with occasional reset
        scen_begin();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 599) == 0) apply_reset(int'($urandom_range(1, 3)));
            else if ($urandom_range(0, 9) == 0) cycle_step(~frame_req);
            else cycle_step(frame_req);
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
